// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared R22SDF FFT helpers.
// Holds the bit-reverse function, which the reorder buffer and the
// twiddle-address logic both use, and the read-FSM state type.
package fft_bitrev_reorder_pkg;

  // Widest index the bit-reverse helper supports.
  localparam int unsigned BITREV_MAX_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_e;

  // Reverses the low nbits bits of v. All bits at or above nbits come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                      input int unsigned nbits);
    logic [BITREV_MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
      if (i < nbits) res[i] = v[nbits-1-i];
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM with one write port and one
// registered read port. The read latency is 1 cycle.
//   clk_i   : clock
//   rst_i   : sync active-high reset. It clears only the read register.
//   we_i    : write enable
//   waddr_i : write address. The MSB selects the bank.
//   wdata_i : write data
//   re_i    : read enable. The read register holds its value when re_i is low.
//   raddr_i : read address. The MSB selects the bank.
//   rdata_o : registered read data
module fft_reorder_ram #(
  parameter int WIDTH  = 50,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The read register is cleared so the block outputs read zero after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: converts bit-reversed R22SDF output frames to natural
// order using two ping-pong banks.
//   clk_i          : clock, rising edge
//   rst_i          : sync active-high reset
//   valid_i        : an input sample is present this cycle
//   x_re_i, x_im_i : input sample, in bit-reversed frame order
//   valid_o        : an output sample is present this cycle
//   last_o         : marks output index N-1
//   z_re_o, z_im_o : output sample, in natural order; held while valid_o is low
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int N_LOG2     = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  output logic                         valid_o,
  output logic                         last_o,
  output logic signed [DATA_WIDTH-1:0] z_re_o,
  output logic signed [DATA_WIDTH-1:0] z_im_o
);

  logic [N_LOG2-1:0]       w_q;
  logic                    wr_bank_q;
  logic [N_LOG2-1:0]       wr_rev;
  logic                    wr_last;
  logic [1:0]              full_q, full_d;
  rd_state_e               state_q, state_d;
  logic [N_LOG2-1:0]       r_q, r_d;
  logic                    rd_bank_q, rd_bank_d;
  logic                    rel_bank;
  logic                    valid_q, last_q;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign wr_rev  = N_LOG2'(bitrev(BITREV_MAX_W'(w_q), N_LOG2));
  assign wr_last = valid_i && (&w_q);

  // Read sequencing. The RAM is addressed with the next-state address so
  // that its 1-cycle read latency lines up with the registered valid_o.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    rd_bank_d = rd_bank_q;
    rel_bank  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|full_q) begin
          state_d   = ST_READ;
          r_d       = '0;
          rd_bank_d = ~full_q[0];
        end
      end
      ST_READ: begin
        if (&r_q) begin
          rel_bank = 1'b1;
          r_d      = '0;
          // If the other bank is already waiting, keep reading so back-to-back frames stay contiguous.
          if (full_q[~rd_bank_q]) rd_bank_d = ~rd_bank_q;
          else                    state_d   = ST_IDLE;
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The released bank and the bank being filled are always different banks.
  always_comb begin
    full_d = full_q;
    if (rel_bank) full_d[rd_bank_q] = 1'b0;
    if (wr_last)  full_d[wr_bank_q] = 1'b1;
  end

  // Write and read control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_q       <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      state_q   <= ST_IDLE;
      r_q       <= '0;
      rd_bank_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (valid_i) w_q <= w_q + 1'b1;
      if (wr_last) wr_bank_q <= ~wr_bank_q;
      full_q    <= full_d;
      state_q   <= state_d;
      r_q       <= r_d;
      rd_bank_q <= rd_bank_d;
      valid_q   <= (state_d == ST_READ);
      last_q    <= (state_d == ST_READ) && (&r_d);
    end
  end

  fft_reorder_ram #(
    .WIDTH  (2*DATA_WIDTH),
    .ADDR_W (N_LOG2+1)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (valid_i),
    .waddr_i ({wr_bank_q, wr_rev}),
    .wdata_i ({x_re_i, x_im_i}),
    .re_i    (state_d == ST_READ),
    .raddr_i ({rd_bank_d, r_d}),
    .rdata_o (rd_data)
  );

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign z_re_o  = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign z_im_o  = rd_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with N = 8 and 25-bit samples.
module tb_fft_bitrev_reorder;

  localparam int DW = 25;
  localparam logic signed [DW-1:0] MINV = 25'sh1000000;
  localparam logic signed [DW-1:0] MAXV = 25'sh0FFFFFF;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 valid_i;
  logic signed [DW-1:0] x_re_i, x_im_i;
  logic                 valid_o, last_o;
  logic signed [DW-1:0] z_re_o, z_im_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_cyc;
  int rv [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  typedef struct {
    int                   c;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 last;
  } obs_t;
  obs_t obs_q[$];

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_LOG2(3)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .x_re_i  (x_re_i),
    .x_im_i  (x_im_i),
    .valid_o (valid_o),
    .last_o  (last_o),
    .z_re_o  (z_re_o),
    .z_im_o  (z_im_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid_o === 1'b1) obs_q.push_back('{cyc, z_re_o, z_im_o, last_o});

  task automatic drive_sample(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    @(posedge clk); #1;
    valid_i = 1'b1; x_re_i = re; x_im_i = im;
    last_cyc = cyc;
  endtask

  task automatic drive_idle();
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; x_re_i = '0; x_im_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_tests++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", last_o); end
    n_tests++; if (z_re_o !== '0) begin n_fail++; $display("FAIL reset_zre got %0d want 0", z_re_o); end
    n_tests++; if (z_im_o !== '0) begin n_fail++; $display("FAIL reset_zim got %0d want 0", z_im_o); end
  endtask

  task automatic test_single_frame();
    int t;
    logic signed [DW-1:0] er, ei;
    obs_q.delete();
    for (int i = 0; i < 8; i++) drive_sample(DW'(rv[i]), DW'(-(rv[i] + 1) * 1000));
    t = last_cyc;
    drive_idle();
    wait_cycles(12);
    n_tests++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL single_count got %0d want 8", obs_q.size()); end
    for (int k = 0; k < 8; k++) begin
      er = DW'(k); ei = DW'(-(k + 1) * 1000);
      n_tests++;
      if (k >= obs_q.size()) begin n_fail++; $display("FAIL single_k%0d missing output", k); end
      else if (obs_q[k].c !== t + 2 + k || obs_q[k].re !== er || obs_q[k].im !== ei || obs_q[k].last !== (k == 7)) begin
        n_fail++;
        $display("FAIL single_k%0d got cyc=%0d re=%0d im=%0d last=%b want cyc=%0d re=%0d im=%0d last=%b",
                 k, obs_q[k].c, obs_q[k].re, obs_q[k].im, obs_q[k].last, t + 2 + k, er, ei, k == 7);
      end
    end
    er = DW'(7); ei = DW'(-8000);
    n_tests++;
    if (valid_o !== 1'b0 || z_re_o !== er || z_im_o !== ei) begin
      n_fail++;
      $display("FAIL single_hold got v=%b re=%0d im=%0d want v=0 re=%0d im=%0d", valid_o, z_re_o, z_im_o, er, ei);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int k;
    logic signed [DW-1:0] er, ei;
    obs_q.delete();
    t = 0;
    for (int i = 0; i < 16; i++) begin
      drive_sample(DW'(rv[i % 8] + (i / 8) * 8), DW'(i));
      if (i == 7) t = last_cyc;
    end
    drive_idle();
    wait_cycles(20);
    n_tests++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL b2b_count got %0d want 16", obs_q.size()); end
    for (int j = 0; j < 16; j++) begin
      k = j % 8;
      er = DW'(j); ei = DW'((j / 8) * 8 + rv[k]);
      n_tests++;
      if (j >= obs_q.size()) begin n_fail++; $display("FAIL b2b_j%0d missing output", j); end
      else if (obs_q[j].c !== t + 2 + j || obs_q[j].re !== er || obs_q[j].im !== ei || obs_q[j].last !== (k == 7)) begin
        n_fail++;
        $display("FAIL b2b_j%0d got cyc=%0d re=%0d im=%0d last=%b want cyc=%0d re=%0d im=%0d last=%b",
                 j, obs_q[j].c, obs_q[j].re, obs_q[j].im, obs_q[j].last, t + 2 + j, er, ei, k == 7);
      end
    end
  endtask

  task automatic test_gaps();
    int t;
    logic signed [DW-1:0] er, ei;
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive_sample(DW'(rv[i] + 32), DW'(-rv[i] - 1));
      if (i == 1 || i == 4) drive_idle();
      if (i == 3) begin drive_idle(); drive_idle(); end
    end
    t = last_cyc;
    drive_idle();
    wait_cycles(12);
    n_tests++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL gaps_count got %0d want 8", obs_q.size()); end
    for (int k = 0; k < 8; k++) begin
      er = DW'(k + 32); ei = DW'(-k - 1);
      n_tests++;
      if (k >= obs_q.size()) begin n_fail++; $display("FAIL gaps_k%0d missing output", k); end
      else if (obs_q[k].c !== t + 2 + k || obs_q[k].re !== er || obs_q[k].im !== ei || obs_q[k].last !== (k == 7)) begin
        n_fail++;
        $display("FAIL gaps_k%0d got cyc=%0d re=%0d im=%0d want cyc=%0d re=%0d im=%0d",
                 k, obs_q[k].c, obs_q[k].re, obs_q[k].im, t + 2 + k, er, ei);
      end
    end
  endtask

  task automatic test_reset_partial();
    int t;
    logic signed [DW-1:0] er, ei;
    obs_q.delete();
    for (int i = 0; i < 5; i++) drive_sample(DW'(100 + i), DW'(200 + i));
    pulse_reset();
    wait_cycles(10);
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL partial_no_output got %0d outputs want 0", obs_q.size()); end
    for (int i = 0; i < 8; i++) drive_sample(DW'(rv[i] + 16), DW'(rv[i] * 2));
    t = last_cyc;
    drive_idle();
    wait_cycles(12);
    n_tests++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL partial_count got %0d want 8", obs_q.size()); end
    for (int k = 0; k < 8; k++) begin
      er = DW'(k + 16); ei = DW'(k * 2);
      n_tests++;
      if (k >= obs_q.size()) begin n_fail++; $display("FAIL partial_k%0d missing output", k); end
      else if (obs_q[k].c !== t + 2 + k || obs_q[k].re !== er || obs_q[k].im !== ei) begin
        n_fail++;
        $display("FAIL partial_k%0d got cyc=%0d re=%0d im=%0d want cyc=%0d re=%0d im=%0d",
                 k, obs_q[k].c, obs_q[k].re, obs_q[k].im, t + 2 + k, er, ei);
      end
    end
  endtask

  task automatic test_reset_midread();
    int t;
    int guard;
    obs_q.delete();
    for (int i = 0; i < 8; i++) drive_sample(DW'(rv[i] + 48), DW'(5));
    t = last_cyc;
    drive_idle();
    guard = 0;
    while (cyc < t + 5 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    n_tests++;
    if (cyc != t + 5) begin n_fail++; $display("FAIL midread_sync got cyc=%0d want %0d", cyc, t + 5); end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (valid_o !== 1'b0 || z_re_o !== '0 || z_im_o !== '0 || last_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midread_clear got v=%b last=%b re=%0d im=%0d want all 0", valid_o, last_o, z_re_o, z_im_o);
    end
    wait_cycles(15);
    n_tests++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL midread_count got %0d want 4", obs_q.size()); end
  endtask

  task automatic test_extremes();
    int t;
    logic signed [DW-1:0] er, ei;
    obs_q.delete();
    for (int i = 0; i < 8; i++) drive_sample((i % 2 == 0) ? MINV : MAXV, (i % 2 == 0) ? MAXV : MINV);
    t = last_cyc;
    drive_idle();
    wait_cycles(12);
    n_tests++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL extreme_count got %0d want 8", obs_q.size()); end
    for (int k = 0; k < 8; k++) begin
      er = (k < 4) ? MINV : MAXV;
      ei = (k < 4) ? MAXV : MINV;
      n_tests++;
      if (k >= obs_q.size()) begin n_fail++; $display("FAIL extreme_k%0d missing output", k); end
      else if (obs_q[k].c !== t + 2 + k || obs_q[k].re !== er || obs_q[k].im !== ei || obs_q[k].last !== (k == 7)) begin
        n_fail++;
        $display("FAIL extreme_k%0d got cyc=%0d re=%0d im=%0d want cyc=%0d re=%0d im=%0d",
                 k, obs_q[k].c, obs_q[k].re, obs_q[k].im, t + 2 + k, er, ei);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gaps();
    test_reset_partial();
    test_reset_midread();
    test_extremes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
